// File: rtl/msx_io_bus_router_pkg.sv
// Shared types and constants for the MSX I/O bus router.
package msx_io_bus_router_pkg;

  // Router transaction state
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_RESP
  } state_e;

  // Value presented on the upstream read bus when nothing drives it
  localparam logic [7:0] IDLE_DATA = 8'hFF;

  // Channel index width; covers up to 8 downstream devices
  localparam int IDX_W = 3;

  localparam int DEF_NUM_CH = 2;
  localparam int DEF_ADDR_W = 8;

  // VDP-style default map: channel 0 at 98h-9Bh, channel 1 at 9Ch-9Fh
  localparam logic [DEF_NUM_CH*DEF_ADDR_W-1:0] DEF_CH_BASE = {8'h9C, 8'h98};
  localparam logic [DEF_NUM_CH*DEF_ADDR_W-1:0] DEF_CH_MASK = {8'hFC, 8'hFC};

endpackage

// File: rtl/msx_io_bus_router_if.sv
// Upstream slot bus plus shared downstream channel bus.
interface msx_io_bus_router_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 8
) ();

  // upstream request / response
  logic [ADDR_W-1:0]      bus_address;
  logic                   bus_ioreq;
  logic                   bus_write;
  logic                   bus_valid;
  logic [7:0]             bus_wdata;
  logic                   bus_ready;
  logic [7:0]             bus_rdata;
  logic                   bus_rdata_en;

  // downstream request / response
  logic [ADDR_W-1:0]      ch_address;
  logic                   ch_write;
  logic [7:0]             ch_wdata;
  logic [NUM_CH-1:0]      ch_valid;
  logic [NUM_CH-1:0]      ch_ready;
  logic [NUM_CH-1:0][7:0] ch_rdata;
  logic [NUM_CH-1:0]      ch_rdata_en;

  // router side
  modport slave (
    input  bus_address, bus_ioreq, bus_write, bus_valid, bus_wdata,
    output bus_ready, bus_rdata, bus_rdata_en,
    output ch_address, ch_write, ch_wdata, ch_valid,
    input  ch_ready, ch_rdata, ch_rdata_en
  );

  // environment side: slot master and the devices
  modport master (
    output bus_address, bus_ioreq, bus_write, bus_valid, bus_wdata,
    input  bus_ready, bus_rdata, bus_rdata_en,
    input  ch_address, ch_write, ch_wdata, ch_valid,
    output ch_ready, ch_rdata, ch_rdata_en
  );

endinterface

// File: rtl/msx_io_bus_router_decoder.sv
// Priority address decoder: lowest matching channel wins.
module msx_io_addr_decoder
  import msx_io_bus_router_pkg::*;
#(
  parameter int                          NUM_CH  = DEF_NUM_CH,
  parameter int                          ADDR_W  = DEF_ADDR_W,
  parameter logic [NUM_CH*ADDR_W-1:0]    CH_BASE = DEF_CH_BASE,
  parameter logic [NUM_CH*ADDR_W-1:0]    CH_MASK = DEF_CH_MASK
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  logic [NUM_CH-1:0] match;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_match
    assign match[i] = ((addr & CH_MASK[i*ADDR_W +: ADDR_W]) ==
                       (CH_BASE[i*ADDR_W +: ADDR_W] & CH_MASK[i*ADDR_W +: ADDR_W]));
  end

  // Scan high to low so the lowest matching index is the last one written
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/msx_io_bus_router.sv
// Routes upstream I/O requests to one of NUM_CH devices, one at a time.
module msx_io_bus_router
  import msx_io_bus_router_pkg::*;
#(
  parameter int                       NUM_CH     = DEF_NUM_CH,
  parameter int                       ADDR_W     = DEF_ADDR_W,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE    = DEF_CH_BASE,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_MASK    = DEF_CH_MASK,
  parameter int                       RD_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  msx_io_bus_router_if.slave        bus,
  input  logic [NUM_CH-1:0]         ch_int_n,
  output logic                      int_n,
  output logic                      timeout_flag,
  output logic [2:0]                timeout_ch
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               write_q, write_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic               miss_q, miss_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0]  ch_valid_q, ch_valid_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               rdata_en_q, rdata_en_d;
  logic               int_n_q, int_n_d;
  logic               to_flag_q, to_flag_d;
  logic [2:0]         to_ch_q, to_ch_d;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;

  logic               sel_ready;
  logic               sel_rd_en;
  logic [7:0]         sel_rdata;

  msx_io_addr_decoder #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .CH_BASE (CH_BASE),
    .CH_MASK (CH_MASK)
  ) u_dec (
    .addr (bus.bus_address),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Pick out the selected channel's handshake and read data
  always_comb begin
    sel_ready = 1'b0;
    sel_rd_en = 1'b0;
    sel_rdata = IDLE_DATA;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_q == IDX_W'(i)) begin
        sel_ready = bus.ch_ready[i];
        sel_rd_en = bus.ch_rdata_en[i];
        sel_rdata = bus.ch_rdata[i];
      end
    end
  end

  // Next-state and next-output logic for the transaction FSM
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    miss_d     = miss_q;
    cnt_d      = cnt_q;
    ch_valid_d = ch_valid_q;
    rdata_d    = IDLE_DATA;
    rdata_en_d = 1'b0;
    int_n_d    = &ch_int_n;
    to_flag_d  = to_flag_q;
    to_ch_d    = to_ch_q;

    case (state_q)
      ST_IDLE: begin
        // Non-I/O cycles and unmatched writes are swallowed here;
        // an unmatched read still passes through ISSUE to get its FFh
        if (bus.bus_valid && bus.bus_ioreq && (dec_hit || !bus.bus_write)) begin
          addr_d  = bus.bus_address;
          write_d = bus.bus_write;
          wdata_d = bus.bus_wdata;
          sel_d   = dec_idx;
          miss_d  = !dec_hit;
          state_d = ST_ISSUE;
          for (int i = 0; i < NUM_CH; i++)
            ch_valid_d[i] = dec_hit && (dec_idx == IDX_W'(i));
        end
      end

      ST_ISSUE: begin
        if (miss_q) begin
          state_d    = ST_RESP;
          rdata_en_d = 1'b1;
          rdata_d    = IDLE_DATA;
        end else if (sel_ready) begin
          ch_valid_d = '0;
          if (write_q) begin
            state_d = ST_IDLE;
          end else if (sel_rd_en) begin
            state_d    = ST_RESP;
            rdata_en_d = 1'b1;
            rdata_d    = sel_rdata;
          end else begin
            state_d = ST_WAIT_RD;
            cnt_d   = '0;
          end
        end
      end

      ST_WAIT_RD: begin
        // Real data on the last allowed cycle still beats the timeout
        if (sel_rd_en) begin
          state_d    = ST_RESP;
          rdata_en_d = 1'b1;
          rdata_d    = sel_rdata;
          cnt_d      = '0;
        end else if (cnt_q == 16'(RD_TIMEOUT - 1)) begin
          state_d    = ST_RESP;
          rdata_en_d = 1'b1;
          rdata_d    = IDLE_DATA;
          cnt_d      = '0;
          to_flag_d  = 1'b1;
          to_ch_d    = 3'(sel_q);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // All router state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      sel_q      <= '0;
      miss_q     <= 1'b0;
      cnt_q      <= '0;
      ch_valid_q <= '0;
      rdata_q    <= IDLE_DATA;
      rdata_en_q <= 1'b0;
      int_n_q    <= 1'b1;
      to_flag_q  <= 1'b0;
      to_ch_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      miss_q     <= miss_d;
      cnt_q      <= cnt_d;
      ch_valid_q <= ch_valid_d;
      rdata_q    <= rdata_d;
      rdata_en_q <= rdata_en_d;
      int_n_q    <= int_n_d;
      to_flag_q  <= to_flag_d;
      to_ch_q    <= to_ch_d;
    end
  end

  assign bus.bus_ready    = (state_q == ST_IDLE);
  assign bus.bus_rdata    = rdata_q;
  assign bus.bus_rdata_en = rdata_en_q;
  assign bus.ch_address   = addr_q;
  assign bus.ch_write     = write_q;
  assign bus.ch_wdata     = wdata_q;
  assign bus.ch_valid     = ch_valid_q;

  assign int_n        = int_n_q;
  assign timeout_flag = to_flag_q;
  assign timeout_ch   = to_ch_q;

endmodule

// File: doc/msx_io_bus_router.md
MSX_IO_BUS_ROUTER -- requirements
Module: msx_io_bus_router

Interface
REQ-001 Parameter NUM_CH, default 2, number of downstream I/O devices (1..8).
REQ-002 Parameter ADDR_W, default 8, width of the I/O port address.
REQ-003 Parameter CH_BASE, default {8'h9C,8'h98}, packed NUM_CH×ADDR_W match bases, channel 0 in the LSBs.
REQ-004 Parameter CH_MASK, default {8'hFC,8'hFC}, packed NUM_CH×ADDR_W match masks; a 1 bit means the address bit is compared.
REQ-005 Parameter RD_TIMEOUT, default 255, read-data wait limit in clk cycles (1..65535).
REQ-006 Port clk, input, 1: the single clock; one clock, all logic on its rising edge.
REQ-007 Port reset, input, 1: reset is synchronous and active-high.
REQ-008 Ports bus_address in ADDR_W, bus_ioreq in 1, bus_write in 1, bus_valid in 1, bus_wdata in 8: upstream request from the slot interface.
REQ-009 Ports bus_ready out 1, bus_rdata out 8, bus_rdata_en out 1: upstream response.
REQ-010 Ports ch_address out ADDR_W, ch_write out 1, ch_wdata out 8: shared downstream request fields.
REQ-011 Ports ch_valid out NUM_CH, ch_ready in NUM_CH: per-channel request handshake.
REQ-012 Ports ch_rdata in NUM_CH×8, ch_rdata_en in NUM_CH: per-channel read responses.
REQ-013 Ports ch_int_n in NUM_CH, int_n out 1: per-channel interrupts and the combined interrupt.
REQ-014 Ports timeout_flag out 1, timeout_ch out 3: sticky diagnostics for the debugger.

Function
REQ-015 A request SHALL be accepted on a cycle with bus_valid=1 and bus_ready=1; bus_ready SHALL be 1 only in IDLE.
REQ-016 Requests with bus_ioreq=0 SHALL be accepted and dropped with no response.
REQ-017 A channel matches when (bus_address & CH_MASK[i]) == (CH_BASE[i] & CH_MASK[i]); on multiple matches the lowest index SHALL win.
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT_RD and RESP.
REQ-019 Transition IDLE->ISSUE on an accepted matched request. The address, write flag, wdata and winning index SHALL be registered at acceptance.
REQ-020 In ISSUE, ch_valid[sel] SHALL be 1 from the cycle after acceptance and held until ch_ready[sel]=1. The other ch_valid bits SHALL be 0.
REQ-021 A write SHALL go ISSUE->IDLE on the ch_ready handshake. A read SHALL go ISSUE->WAIT_RD on that handshake.
REQ-022 In WAIT_RD, ch_rdata_en[sel] at cycle R SHALL produce bus_rdata=ch_rdata[sel] with bus_rdata_en=1 at cycle R+1 (state RESP, one-cycle pulse), then return to IDLE.
REQ-023 If ch_rdata_en[sel] arrives on the same cycle as the ch_ready handshake, that data SHALL be taken and WAIT_RD skipped.
REQ-024 A 16-bit counter SHALL run in WAIT_RD. On reaching RD_TIMEOUT, RESP SHALL return 8'hFF, timeout_flag SHALL be set and timeout_ch SHALL take sel.
REQ-025 An unmatched read SHALL produce bus_rdata=8'hFF with bus_rdata_en=1 two cycles after acceptance. An unmatched write SHALL be dropped.
REQ-026 ch_rdata_en from non-selected channels, or outside WAIT_RD/ISSUE, SHALL be ignored.
REQ-027 When bus_rdata_en=0, bus_rdata SHALL be 8'hFF.
REQ-028 int_n SHALL be the registered AND of ch_int_n, with a latency of 1 cycle.
REQ-029 The ISSUE state SHALL have no timeout; a channel that never asserts ready stalls the bus, matching slot wait behaviour.

Reset
REQ-030 On reset=1 at a clk edge: the state SHALL go to IDLE, the counter to 0, ch_valid to 0, bus_rdata_en to 0, bus_rdata to 8'hFF, int_n to 1, timeout_flag to 0 and timeout_ch to 0.
REQ-031 Reset SHALL abort any in-flight transaction with no response; bus_ready SHALL be 1 the cycle after reset deasserts.
REQ-032 timeout_flag SHALL clear only on reset.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the 8'hFF idle-data constant and the default CH_BASE/CH_MASK values.
REQ-034 Address decode SHALL be one sub-module, msx_io_addr_decoder: a combinational priority match returning a hit flag and an index.

Verification
REQ-035 Write 8'h55 to port 8'h99 with ch_ready[0] delayed 3 cycles -> ch_valid[0] held for 4 cycles, ch_wdata=8'h55, no bus_rdata_en.
REQ-036 Read port 8'h9E; channel 1 returns 8'hA5 two cycles after ready -> bus_rdata=8'hA5 with bus_rdata_en pulsed for 1 cycle.
REQ-037 Read port 8'h40 (no match) -> bus_rdata=8'hFF and bus_rdata_en 2 cycles after acceptance; ch_valid stays 0.
REQ-038 Read channel 0 that never returns data, RD_TIMEOUT=10 -> 8'hFF after 10 wait cycles, timeout_flag=1, timeout_ch=0.
REQ-039 Overlapping CH_BASE for channels 0 and 1, read port 8'h98 -> only ch_valid[0] is asserted.
REQ-040 Assert reset in WAIT_RD, then drive ch_rdata_en -> no bus_rdata_en; the next request completes normally; ch_int_n=2'b10 -> int_n=0 one cycle later.
